// File: rtl/core_muldiv_seq_if.sv
// rtl/core_muldiv_seq_if.sv - request/response handshake bundle between execute and the mul/div sequencer
interface core_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/core_muldiv_seq.sv
// rtl/core_muldiv_seq.sv - iterative RV32M multiply/divide sequencer (radix-2 shift-add / restoring divide)
// Optional early-out on zero operands: define CORE_MULDIV_ZERO_SKIP_EN.
module core_muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    core_muldiv_seq_if.slave    bus,
    output logic                busy
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIXUP, DONE} state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, dvs_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     count_q;
    logic              neg_res_q;
    logic              rsp_valid_q;
    logic [XLEN-1:0]   rsp_data_q;

    logic              is_div, a_signed, b_signed, a_neg, b_neg, neg_res_d;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              special;
    logic [XLEN-1:0]   special_res;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;
    logic [XLEN-1:0]   quot, remd, fix_res;

    assign bus.req_ready = (state == IDLE) & ~flush;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign busy          = (state != IDLE);

    // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
    always_comb begin
        is_div    = op_q[2];
        a_signed  = (op_q == OP_MULH) | (op_q == OP_MULHSU) | (op_q == OP_DIV) | (op_q == OP_REM);
        b_signed  = (op_q == OP_MULH) | (op_q == OP_DIV) | (op_q == OP_REM);
        a_neg     = a_signed & a_q[XLEN-1];
        b_neg     = b_signed & b_q[XLEN-1];
        a_abs     = a_neg ? -a_q : a_q;
        b_abs     = b_neg ? -b_q : b_q;
        neg_res_d = (is_div & op_q[1]) ? a_neg : (a_neg ^ b_neg);

        special     = 1'b0;
        special_res = '0;
        if (is_div && (b_q == '0)) begin
            special     = 1'b1;
            special_res = op_q[1] ? a_q : '1;
        end else if (is_div && !op_q[0] && (a_q == INT_MIN) && (b_q == '1)) begin
            special     = 1'b1;
            special_res = op_q[1] ? '0 : INT_MIN;
        end
`ifdef CORE_MULDIV_ZERO_SKIP_EN
        else if (!is_div && ((a_q == '0) || (b_q == '0))) begin
            special     = 1'b1;
            special_res = '0;
        end else if (is_div && (a_q == '0)) begin
            special     = 1'b1;
            special_res = '0;
        end
`endif
    end

    // acc_q holds {high product, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        div_next = diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        prod = neg_res_q ? -acc_q : acc_q;
        quot = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        remd = neg_res_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quot;
            default:                       fix_res = remd;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            dvs_q       <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            neg_res_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (flush) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q  <= bus.req_op;
                        a_q   <= bus.req_a;
                        b_q   <= bus.req_b;
                        state <= PREP;
                    end
                end
                PREP: begin
                    neg_res_q <= neg_res_d;
                    count_q   <= '0;
                    if (special) begin
                        rsp_data_q  <= special_res;
                        rsp_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        dvs_q <= is_div ? b_abs : a_abs;
                        acc_q <= {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc_q   <= is_div ? div_next : mul_next;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(XLEN - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    rsp_data_q  <= fix_res;
                    rsp_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_muldiv_seq.sv
// tb/tb_core_muldiv_seq.sv - directed self-checking bench for core_muldiv_seq
module tb_core_muldiv_seq;
    logic clk;
    logic rst;
    logic flush;
    logic busy;
    int   pass_cnt;
    int   total_cnt;

    core_muldiv_seq_if #(.XLEN(32)) bus ();

    core_muldiv_seq #(.XLEN(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] data, output int lat, output logic busy_all);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = 32'hDEAD_BEEF;
        bus.req_b     = 32'h1234_5678;
        bus.req_op    = ~op;
        lat      = -1;
        busy_all = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1) busy_all = 1'b0;
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        data = bus.rsp_data;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (bus.req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); else pass_cnt++;
        flush = 1'b1;
        #1;
        total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL flush_gates_req_ready: got %b want 0", bus.req_ready); else pass_cnt++;
        flush = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        logic [31:0] d; int lat; logic ba;
        run_op(3'd0, 32'd7, 32'd6, d, lat, ba);
        total_cnt++; if (d !== 32'd42) $display("FAIL mul_7x6: got %h want %h", d, 32'd42); else pass_cnt++;
        total_cnt++; if (lat != 34) $display("FAIL mul_latency: got %0d want 34", lat); else pass_cnt++;
        total_cnt++; if (ba !== 1'b1) $display("FAIL mul_busy_held: got %b want 1", ba); else pass_cnt++;
        finish_rsp();
        total_cnt++; if (busy !== 1'b0) $display("FAIL mul_busy_after: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL mul_valid_after: got %b want 0", bus.rsp_valid); else pass_cnt++;
    endtask

    task automatic test_mulh();
        logic [31:0] d; int lat; logic ba;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, lat, ba);
        total_cnt++; if (d !== 32'h0) $display("FAIL mulh_m1xm1: got %h want 0", d); else pass_cnt++;
        total_cnt++; if (lat != 34) $display("FAIL mulh_latency: got %0d want 34", lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d, lat, ba);
        total_cnt++; if (d !== 32'hFFFF_FFFE) $display("FAIL mulhu_max: got %h want fffffffe", d); else pass_cnt++;
        finish_rsp();
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, d, lat, ba);
        total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL mulhsu_m1x2: got %h want ffffffff", d); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_div();
        logic [31:0] d; int lat; logic ba;
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, d, lat, ba);
        total_cnt++; if (d !== 32'hFFFF_FFFD) $display("FAIL div_m7_2: got %h want fffffffd", d); else pass_cnt++;
        total_cnt++; if (lat != 34) $display("FAIL div_latency: got %0d want 34", lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, d, lat, ba);
        total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL rem_m7_2: got %h want ffffffff", d); else pass_cnt++;
        finish_rsp();
        run_op(3'd5, 32'd100, 32'd7, d, lat, ba);
        total_cnt++; if (d !== 32'd14) $display("FAIL divu_100_7: got %h want %h", d, 32'd14); else pass_cnt++;
        finish_rsp();
        run_op(3'd7, 32'd100, 32'd7, d, lat, ba);
        total_cnt++; if (d !== 32'd2) $display("FAIL remu_100_7: got %h want %h", d, 32'd2); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_special();
        logic [31:0] d; int lat; logic ba;
        run_op(3'd5, 32'd5, 32'd0, d, lat, ba);
        total_cnt++; if (d !== 32'hFFFF_FFFF) $display("FAIL divu_by0: got %h want ffffffff", d); else pass_cnt++;
        total_cnt++; if (lat != 1) $display("FAIL divu_by0_latency: got %0d want 1", lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd6, 32'd5, 32'd0, d, lat, ba);
        total_cnt++; if (d !== 32'd5) $display("FAIL rem_by0: got %h want 5", d); else pass_cnt++;
        total_cnt++; if (lat != 1) $display("FAIL rem_by0_latency: got %0d want 1", lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, ba);
        total_cnt++; if (d !== 32'h8000_0000) $display("FAIL div_ovf: got %h want 80000000", d); else pass_cnt++;
        total_cnt++; if (lat != 1) $display("FAIL div_ovf_latency: got %0d want 1", lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, d, lat, ba);
        total_cnt++; if (d !== 32'h0) $display("FAIL rem_ovf: got %h want 0", d); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_backpressure();
        logic [31:0] d; int lat; logic ba;
        run_op(3'd5, 32'd100, 32'd7, d, lat, ba);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total_cnt++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid_hold[%0d]: got %b want 1", i, bus.rsp_valid); else pass_cnt++;
            total_cnt++; if (bus.rsp_data !== 32'd14) $display("FAIL bp_data_hold[%0d]: got %h want %h", i, bus.rsp_data, 32'd14); else pass_cnt++;
            total_cnt++; if (bus.req_ready !== 1'b0) $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); else pass_cnt++;
        end
        bus.req_valid = 1'b0;
        finish_rsp();
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL bp_busy_drop: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_flush();
        logic [31:0] d; int lat; logic ba; logic seen;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd123;
        bus.req_b     = 32'd456;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_calc_busy: got %b want 0", busy); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b0) $display("FAIL flush_no_rsp: got %b want 0", seen); else pass_cnt++;
        run_op(3'd0, 32'd3, 32'd3, d, lat, ba);
        total_cnt++; if (d !== 32'd9) $display("FAIL flush_then_mul: got %h want 9", d); else pass_cnt++;
        total_cnt++; if (lat != 34) $display("FAIL flush_then_mul_latency: got %0d want 34", lat); else pass_cnt++;
        finish_rsp();
        // flush in DONE against a simultaneous response and request handshake
        run_op(3'd5, 32'd5, 32'd0, d, lat, ba);
        flush         = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd0;
        @(posedge clk);
        #1;
        flush         = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL flush_done_valid: got %b want 0", bus.rsp_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_blocks_accept: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d; int lat; logic ba;
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd5;
        bus.req_a     = 32'd1000;
        bus.req_b     = 32'd3;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL async_rst_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid !== 1'b0) $display("FAIL async_rst_valid: got %b want 0", bus.rsp_valid); else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_op(3'd0, 32'd3, 32'd3, d, lat, ba);
        total_cnt++; if (d !== 32'd9) $display("FAIL after_rst_mul: got %h want 9", d); else pass_cnt++;
        finish_rsp();
    endtask

    task automatic test_zero_operands();
        logic [31:0] d; int lat; logic ba; int exp_lat;
`ifdef CORE_MULDIV_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 34;
`endif
        run_op(3'd0, 32'd0, 32'd9, d, lat, ba);
        total_cnt++; if (d !== 32'd0) $display("FAIL mul_zero: got %h want 0", d); else pass_cnt++;
        total_cnt++; if (lat != exp_lat) $display("FAIL mul_zero_latency: got %0d want %0d", lat, exp_lat); else pass_cnt++;
        finish_rsp();
        run_op(3'd7, 32'd0, 32'd5, d, lat, ba);
        total_cnt++; if (d !== 32'd0) $display("FAIL remu_zero: got %h want 0", d); else pass_cnt++;
        total_cnt++; if (lat != exp_lat) $display("FAIL remu_zero_latency: got %0d want %0d", lat, exp_lat); else pass_cnt++;
        finish_rsp();
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst           = 1'b0;
        flush         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_zero_operands();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
